enigma_rotor_path: RTL and testbench

- Sequential Enigma datapath that drives the reflector's input and consumes its output.
- Per accepted keypress: step the rotors, pass the letter forward through the right, middle and left rotors, and send it to the reflector.
- Capture the reflected letter, pass it backward through the inverse rotors, and present the lamp letter.
- Letter encoding throughout is 1..26 = A..Z, the same encoding the reflector uses (pairs 1..13 with 14..26).

---
 rtl/enigma_rotor_path.sv | 181 ++++++++++++++++++
 tb/tb_enigma_rotor_path.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enigma_rotor_path.sv
// Enigma rotor datapath (rotors I-II-III): steps the rotors per key, runs the
// forward pass, hands the letter to an external reflector, runs the inverse
// pass and pulses the lamp letter. One working register is shared by all passes.
module enigma_rotor_path #(
    parameter logic [4:0] NOTCH_L = 5'd16,
    parameter logic [4:0] NOTCH_M = 5'd4,
    parameter logic [4:0] NOTCH_R = 5'd21
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [4:0]  key_in,
    output logic        key_ready,
    input  logic        pos_load,
    input  logic [14:0] pos_in,
    output logic [14:0] pos_out,
    output logic [4:0]  ref_out,
    input  logic [4:0]  ref_in,
    output logic        lamp_valid,
    output logic [4:0]  lamp_out
);

    typedef enum logic [2:0] {IDLE, STEP, FWD, REFL_SEND, REFL_CAP, BWD, DONE} state_t;

    localparam logic [1:0] ROT_R = 2'd0;
    localparam logic [1:0] ROT_M = 2'd1;
    localparam logic [1:0] ROT_L = 2'd2;

    // Wirings, 0-based index -> 0-based letter, and their inverses.
    localparam logic [4:0] WIRE_L [26] = '{5'd4, 5'd10, 5'd12, 5'd5, 5'd11, 5'd6, 5'd3, 5'd16, 5'd21, 5'd25, 5'd13, 5'd19, 5'd14,
                                           5'd22, 5'd24, 5'd7, 5'd23, 5'd20, 5'd18, 5'd15, 5'd0, 5'd8, 5'd1, 5'd17, 5'd2, 5'd9};
    localparam logic [4:0] WIRE_M [26] = '{5'd0, 5'd9, 5'd3, 5'd10, 5'd18, 5'd8, 5'd17, 5'd20, 5'd23, 5'd1, 5'd11, 5'd7, 5'd22,
                                           5'd19, 5'd12, 5'd2, 5'd16, 5'd6, 5'd25, 5'd13, 5'd15, 5'd24, 5'd5, 5'd21, 5'd14, 5'd4};
    localparam logic [4:0] WIRE_R [26] = '{5'd1, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd2, 5'd15, 5'd17, 5'd19, 5'd23, 5'd21, 5'd25,
                                           5'd13, 5'd24, 5'd4, 5'd8, 5'd22, 5'd6, 5'd0, 5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14};
    localparam logic [4:0] INV_L  [26] = '{5'd20, 5'd22, 5'd24, 5'd6, 5'd0, 5'd3, 5'd5, 5'd15, 5'd21, 5'd25, 5'd1, 5'd4, 5'd2,
                                           5'd10, 5'd12, 5'd19, 5'd7, 5'd23, 5'd18, 5'd11, 5'd17, 5'd8, 5'd13, 5'd16, 5'd14, 5'd9};
    localparam logic [4:0] INV_M  [26] = '{5'd0, 5'd9, 5'd15, 5'd2, 5'd25, 5'd22, 5'd17, 5'd11, 5'd5, 5'd1, 5'd3, 5'd10, 5'd14,
                                           5'd19, 5'd24, 5'd20, 5'd16, 5'd6, 5'd4, 5'd13, 5'd7, 5'd23, 5'd12, 5'd8, 5'd21, 5'd18};
    localparam logic [4:0] INV_R  [26] = '{5'd19, 5'd0, 5'd6, 5'd1, 5'd15, 5'd2, 5'd18, 5'd3, 5'd16, 5'd4, 5'd20, 5'd5, 5'd21,
                                           5'd13, 5'd25, 5'd7, 5'd24, 5'd8, 5'd23, 5'd9, 5'd22, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12};

    function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 6'd26) s = s - 6'd26;
        return s[4:0];
    endfunction

    function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + 6'd26 - {1'b0, b};
        if (s >= 6'd26) s = s - 6'd26;
        return s[4:0];
    endfunction

    function automatic logic [4:0] inc26(input logic [4:0] a);
        return (a == 5'd25) ? 5'd0 : a + 5'd1;
    endfunction

    function automatic logic [4:0] clamp_pos(input logic [4:0] a);
        return (a > 5'd25) ? 5'd0 : a;
    endfunction

    function automatic logic [4:0] wire_lookup(input logic [1:0] rotor, input logic inverse,
                                               input logic [4:0] idx);
        logic [4:0] w;
        w = 5'd0;
        case ({inverse, rotor})
            {1'b0, ROT_R}: w = WIRE_R[idx];
            {1'b0, ROT_M}: w = WIRE_M[idx];
            {1'b0, ROT_L}: w = WIRE_L[idx];
            {1'b1, ROT_R}: w = INV_R[idx];
            {1'b1, ROT_M}: w = INV_M[idx];
            {1'b1, ROT_L}: w = INV_L[idx];
            default:       w = 5'd0;
        endcase
        return w;
    endfunction

    state_t     state, state_nxt;
    logic [1:0] sub, sub_nxt;
    logic [4:0] pos_l, pos_m, pos_r;
    logic [4:0] acc;
    logic       key_ok;
    logic [1:0] rotor;
    logic [4:0] pass_pos, pass_out;

    assign key_ok     = (key_in != 5'd0) && (key_in <= 5'd26);
    assign key_ready  = (state == IDLE) && !pos_load;
    assign lamp_valid = (state == DONE);
    assign pos_out    = {pos_l, pos_m, pos_r};

    // One rotor pass on the working letter; the sub-index picks the rotor, the state the direction.
    always_comb begin
        rotor    = (state == BWD) ? (ROT_L - sub) : sub;
        pass_pos = pos_l;
        case (rotor)
            ROT_R:   pass_pos = pos_r;
            ROT_M:   pass_pos = pos_m;
            default: pass_pos = pos_l;
        endcase
        pass_out = sub26(wire_lookup(rotor, state == BWD, add26(acc, pass_pos)), pass_pos);
    end

    // State and sub-index register.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
        if (rst) begin
            state <= IDLE;
            sub   <= 2'd0;
        end else begin
            state <= state_nxt;
            sub   <= sub_nxt;
        end
    end

    // Next-state sequencing through step, forward, reflector handshake and backward passes.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
        state_nxt = state;
        sub_nxt   = sub;
        case (state)
            IDLE:      if (key_valid && key_ready && key_ok) state_nxt = STEP;
            STEP:      begin state_nxt = FWD; sub_nxt = 2'd0; end
            FWD:       if (sub == 2'd2) begin state_nxt = REFL_SEND; sub_nxt = 2'd0; end
                       else sub_nxt = sub + 2'd1;
            REFL_SEND: state_nxt = REFL_CAP;
            REFL_CAP:  begin state_nxt = BWD; sub_nxt = 2'd0; end
            BWD:       if (sub == 2'd2) begin state_nxt = DONE; sub_nxt = 2'd0; end
                       else sub_nxt = sub + 2'd1;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Datapath: position load/step, working letter, reflector drive and lamp letter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_l    <= 5'd0;
            pos_m    <= 5'd0;
            pos_r    <= 5'd0;
            acc      <= 5'd0;
            ref_out  <= 5'd0;
            lamp_out <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (pos_load) begin
                        pos_l <= clamp_pos(pos_in[14:10]);
                        pos_m <= clamp_pos(pos_in[9:5]);
                        pos_r <= clamp_pos(pos_in[4:0]);
                    end else if (key_valid && key_ok) begin
                        acc <= key_in - 5'd1;
                    end
                end
                STEP: begin
                    // Notch tests use pre-step positions; middle at its notch double-steps.
                    pos_r <= inc26(pos_r);
                    if (pos_r == NOTCH_R || pos_m == NOTCH_M) pos_m <= inc26(pos_m);
                    if (pos_m == NOTCH_M) pos_l <= inc26(pos_l);
                end
                FWD: begin
                    acc <= pass_out;
                    if (sub == 2'd2) ref_out <= pass_out + 5'd1;
                end
                REFL_CAP: acc <= (ref_in >= 5'd1 && ref_in <= 5'd26) ? ref_in - 5'd1 : 5'd0;
                BWD: begin
                    acc <= pass_out;
                    if (sub == 2'd2) lamp_out <= pass_out + 5'd1;
                end
                default: ;
            endcase
        end
    end

    // Unused parameter kept for completeness of the rotor set: left rotor has no rotor to its left.
    logic unused_notch_l;
    assign unused_notch_l = ^NOTCH_L;

endmodule

// File: tb/tb_enigma_rotor_path.sv
// Self-checking bench for enigma_rotor_path: directed scenarios plus random keys
// compared against a letter-level Enigma model built from the wiring strings.
module tb_enigma_rotor_path;

    logic        clk;
    logic        rst;
    logic        key_valid;
    logic [4:0]  key_in;
    logic        key_ready;
    logic        pos_load;
    logic [14:0] pos_in;
    logic [14:0] pos_out;
    logic [4:0]  ref_out;
    logic [4:0]  ref_in;
    logic        lamp_valid;
    logic [4:0]  lamp_out;

    bit          refl_bad;
    logic [4:0]  refl_bad_val;

    int checks;
    int failures;

    int wire_t [3][26];   // 0 = left (I), 1 = middle (II), 2 = right (III)
    int inv_t  [3][26];
    int m_pos  [3];

    enigma_rotor_path dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_in    (key_in),
        .key_ready (key_ready),
        .pos_load  (pos_load),
        .pos_in    (pos_in),
        .pos_out   (pos_out),
        .ref_out   (ref_out),
        .ref_in    (ref_in),
        .lamp_valid(lamp_valid),
        .lamp_out  (lamp_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reflector pairs 1..13 with 14..26; can be forced to emit an arbitrary value.
    function automatic logic [4:0] reflector(input logic [4:0] v, input bit bad, input logic [4:0] badv);
        if (bad) return badv;
        if (v >= 5'd1 && v <= 5'd13) return v + 5'd13;
        if (v >= 5'd14 && v <= 5'd26) return v - 5'd13;
        return 5'd0;
    endfunction

    always_comb ref_in = reflector(ref_out, refl_bad, refl_bad_val);

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int rot_f(input int r, input int x);
        int p = m_pos[r];
        return (wire_t[r][(x + p) % 26] - p + 26) % 26;
    endfunction

    function automatic int rot_b(input int r, input int x);
        int p = m_pos[r];
        return (inv_t[r][(x + p) % 26] - p + 26) % 26;
    endfunction

    function automatic void model_step();
        bit mid  = (m_pos[2] == 21) || (m_pos[1] == 4);
        bit left = (m_pos[1] == 4);
        m_pos[2] = (m_pos[2] + 1) % 26;
        if (mid)  m_pos[1] = (m_pos[1] + 1) % 26;
        if (left) m_pos[0] = (m_pos[0] + 1) % 26;
    endfunction

    function automatic int packed_pos();
        return m_pos[0] * 1024 + m_pos[1] * 32 + m_pos[2];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int l, input int m, input int r);
        pos_load = 1'b1;
        pos_in   = {5'(l), 5'(m), 5'(r)};
        tick();
        pos_load = 1'b0;
        m_pos[0] = (l > 25) ? 0 : l;
        m_pos[1] = (m > 25) ? 0 : m;
        m_pos[2] = (r > 25) ? 0 : r;
        check("pos_load", int'(pos_out), packed_pos());
    endtask

    // Offer one valid key, follow it cycle by cycle through the whole operation.
    task automatic press(input int key, input bit hold, input bit rand_load, output int lamp_seen);
        int  x, fwd_res, rin, exp_lamp, lamp_hits, exp_pos;
        bit  ready_seen;
        model_step();
        x = key - 1;
        x = rot_f(2, x);
        x = rot_f(1, x);
        x = rot_f(0, x);
        fwd_res = x;
        rin = int'(reflector(5'(fwd_res + 1), refl_bad, refl_bad_val));
        x = (rin >= 1 && rin <= 26) ? rin - 1 : 0;
        x = rot_b(0, x);
        x = rot_b(1, x);
        x = rot_b(2, x);
        exp_lamp = x + 1;
        exp_pos  = packed_pos();

        key_valid = 1'b1;
        key_in    = 5'(key);
        tick();
        if (!hold) key_valid = 1'b0;
        ready_seen = key_ready;
        lamp_hits  = int'(lamp_valid);
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 1) check("pos_after_step", int'(pos_out), exp_pos);
            if (k == 4) check("ref_out_send", int'(ref_out), fwd_res + 1);
            ready_seen = ready_seen | key_ready;
            if (k < 9) lamp_hits += int'(lamp_valid);
            if (rand_load && k <= 7) begin
                pos_load = 1'($urandom_range(0, 1));
                pos_in   = 15'($urandom);
            end else begin
                pos_load = 1'b0;
            end
        end
        lamp_seen = int'(lamp_out);
        check("lamp_valid_done", int'(lamp_valid), 1);
        check("lamp_out", lamp_seen, exp_lamp);
        check("no_early_lamp", lamp_hits, 0);
        check("busy_not_ready", int'(ready_seen), 0);
        tick();
        check("lamp_one_cycle", int'(lamp_valid), 0);
        check("ready_after_done", int'(key_ready), 1);
        check("pos_held", int'(pos_out), exp_pos);
        check("ref_out_held", int'(ref_out), fwd_res + 1);
    endtask

    // Offer an out-of-range key: consumed without any step or lamp.
    task automatic drop_key(input int key);
        int lamp_hits;
        int exp_pos = packed_pos();
        key_valid = 1'b1;
        key_in    = 5'(key);
        tick();
        key_valid = 1'b0;
        lamp_hits = 0;
        check("bad_key_ready", int'(key_ready), 1);
        for (int k = 0; k < 11; k++) begin
            tick();
            lamp_hits += int'(lamp_valid);
        end
        check("bad_key_no_lamp", lamp_hits, 0);
        check("bad_key_pos", int'(pos_out), exp_pos);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int lamp;
        int lamp_hits;
        string s;

        checks = 0;
        failures = 0;
        for (int r = 0; r < 3; r++) begin
            s = (r == 0) ? "EKMFLGDQVZNTOWYHXUSPAIBRCJ" :
                (r == 1) ? "AJDKSIRUXBLHWTMCQGZNPYFVOE" : "BDFHJLCPRTXVZNYEIWGAKMUSQO";
            for (int i = 0; i < 26; i++) begin
                wire_t[r][i] = int'(s[i]) - 65;
                inv_t[r][wire_t[r][i]] = i;
            end
        end

        rst = 1'b1; key_valid = 1'b0; key_in = 5'd0; pos_load = 1'b0; pos_in = 15'd0;
        refl_bad = 1'b0; refl_bad_val = 5'd0;
        m_pos = '{0, 0, 0};
        tick();
        tick();
        check("rst_pos_out", int'(pos_out), 0);
        check("rst_ref_out", int'(ref_out), 0);
        check("rst_lamp_valid", int'(lamp_valid), 0);
        check("rst_lamp_out", int'(lamp_out), 0);
        check("rst_key_ready", int'(key_ready), 1);
        rst = 1'b0;

        // A at AAA encrypts to B, and B back to A.
        load(0, 0, 0);
        press(1, 1'b0, 1'b0, lamp);
        check("tp_pos_001", int'(pos_out), 1);
        check("tp_A_to_B", lamp, 2);
        load(0, 0, 0);
        press(2, 1'b0, 1'b0, lamp);
        check("tp_B_to_A", lamp, 1);

        // Double-step of the middle rotor.
        load(0, 3, 21);
        press(1, 1'b0, 1'b0, lamp);
        check("dstep_first", int'(pos_out), (0 << 10) | (4 << 5) | 22);
        press(1, 1'b0, 1'b0, lamp);
        check("dstep_second", int'(pos_out), (1 << 10) | (5 << 5) | 23);

        // Wrap of the right rotor and out-of-range load fields.
        load(0, 0, 25);
        press(5, 1'b0, 1'b0, lamp);
        check("wrap_right", int'(pos_out), 0);
        load(30, 7, 31);
        check("load_clamp", int'(pos_out), 7 << 5);

        // key_valid held continuously: one acceptance per 11 cycles.
        load(0, 0, 0);
        press(1, 1'b1, 1'b0, lamp);
        press(1, 1'b1, 1'b0, lamp);
        press(1, 1'b0, 1'b0, lamp);
        check("hold_pos", int'(pos_out), 3);

        // Load and key offered together: load wins, key not taken.
        key_valid = 1'b1; key_in = 5'd3; pos_load = 1'b1; pos_in = {5'd2, 5'd9, 5'd11};
        #1;
        check("load_blocks_ready", int'(key_ready), 0);
        tick();
        key_valid = 1'b0; pos_load = 1'b0;
        m_pos = '{2, 9, 11};
        check("load_key_pos", int'(pos_out), packed_pos());
        lamp_hits = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            lamp_hits += int'(lamp_valid) + int'(!key_ready);
        end
        check("load_key_not_taken", lamp_hits, 0);

        // Out-of-range keys.
        drop_key(0);
        drop_key(27);
        drop_key(31);

        // Reflector returning an out-of-range letter is treated as A.
        refl_bad = 1'b1; refl_bad_val = 5'd29;
        press(4, 1'b0, 1'b0, lamp);
        refl_bad_val = 5'd0;
        press(19, 1'b0, 1'b0, lamp);
        refl_bad = 1'b0;

        // Random keys, loads (some fields out of range) and ignored mid-operation loads.
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 2) == 0)
                load(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
            if ($urandom_range(0, 9) == 0)
                drop_key(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(27, 31)));
            else
                press(int'($urandom_range(1, 26)), 1'b0, 1'b1, lamp);
        end

        // Reset during the backward pass aborts the operation.
        load(3, 4, 5);
        key_valid = 1'b1; key_in = 5'd7;
        tick();
        key_valid = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        rst = 1'b1;
        tick();
        check("abort_key_ready", int'(key_ready), 1);
        check("abort_pos_out", int'(pos_out), 0);
        check("abort_ref_out", int'(ref_out), 0);
        check("abort_lamp_valid", int'(lamp_valid), 0);
        rst = 1'b0;
        m_pos = '{0, 0, 0};
        lamp_hits = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            lamp_hits += int'(lamp_valid);
        end
        check("abort_no_lamp", lamp_hits, 0);
        press(1, 1'b0, 1'b0, lamp);
        check("after_abort_A", lamp, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
